ghost_scheduler: RTL and testbench

- Game-level controller for the ghost datapath.
- Owns the TITLE/PLAYING/GAME_OVER state and the lives counter.
- Generates per-ghost move strobes round-robin from one shared move timer, replacing each ghost's private free-running delay counter.
- Sits between the input/top-level game logic and NUM_GHOSTS ghost movers. It consumes their registered collision flags and drives their respawn.

---
 rtl/ghost_scheduler_if.sv | 30 +++
 rtl/ghost_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_ghost_scheduler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ghost_scheduler_if.sv
// Bus between the top-level game logic and the ghost scheduler.
//   start_i       : debounced start/acknowledge pulse into the scheduler
//   collision_i   : per-ghost registered collision flags into the scheduler
//   move_en_o     : one-hot per-ghost move strobe out of the scheduler
//   ghost_reset_o : respawn pulse out of the scheduler
//   hit_o         : accepted-collision pulse out of the scheduler
//   game_state_o  : 00 TITLE, 10 PLAYING, 11 GAME_OVER
//   lives_o       : remaining lives
// Modports: master = game logic side, slave = scheduler side.
interface ghost_scheduler_if #(
   parameter int unsigned NUM_GHOSTS = 4
);
   logic                  start_i;
   logic [NUM_GHOSTS-1:0] collision_i;
   logic [NUM_GHOSTS-1:0] move_en_o;
   logic                  ghost_reset_o;
   logic                  hit_o;
   logic [1:0]            game_state_o;
   logic [1:0]            lives_o;

   modport master (
      output start_i, collision_i,
      input  move_en_o, ghost_reset_o, hit_o, game_state_o, lives_o
   );

   modport slave (
      input  start_i, collision_i,
      output move_en_o, ghost_reset_o, hit_o, game_state_o, lives_o
   );
endinterface

// File: rtl/ghost_scheduler.sv
// Game-level controller for the ghost datapath: owns the TITLE/PLAYING/
// GAME_OVER state and the lives counter, and issues round-robin per-ghost
// move strobes from one shared move timer.
// Ports:
//   clk_i   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : ghost_scheduler_if.slave (start_i, collision_i in;
//             move_en_o, ghost_reset_o, hit_o, game_state_o, lives_o out)
// Optional feature macro: GHOST_FREEZE_EN -- after each respawn pulse the
// first FREEZE_TICKS ticks start no sweep.
module ghost_scheduler #(
   parameter int unsigned NUM_GHOSTS  = 4,
   parameter int unsigned MOVE_DELAY  = 90000000,
   parameter int unsigned LIVES_INIT  = 3,
   parameter int unsigned HIT_HOLDOFF = 2
`ifdef GHOST_FREEZE_EN
   , parameter int unsigned FREEZE_TICKS = 3
`endif
) (
   input logic             clk_i,
   input logic             reset_n,
   ghost_scheduler_if.slave bus
);

   localparam int unsigned TW = $clog2(MOVE_DELAY);
   localparam int unsigned SW = $clog2(NUM_GHOSTS) + 1;
   localparam int unsigned HW = (HIT_HOLDOFF < 1) ? 1 : $clog2(HIT_HOLDOFF + 1);
`ifdef GHOST_FREEZE_EN
   localparam int unsigned FW = (FREEZE_TICKS < 1) ? 1 : $clog2(FREEZE_TICKS + 1);
`endif

   // Sweep index holds the next ghost to strobe; NUM_GHOSTS means idle.
   localparam logic [SW-1:0] SWEEP_IDLE = SW'(NUM_GHOSTS);

   typedef enum logic [1:0] {
      ST_TITLE     = 2'b00,
      ST_PLAYING   = 2'b10,
      ST_GAME_OVER = 2'b11
   } state_e;

   state_e                state_q, state_d;
   logic [1:0]            lives_q, lives_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [SW-1:0]         sweep_idx_q, sweep_idx_d;
   logic [HW-1:0]         holdoff_q, holdoff_d;
   logic [NUM_GHOSTS-1:0] move_en_q, move_en_d;
   logic                  ghost_reset_q, ghost_reset_d;
   logic                  hit_q, hit_d;
`ifdef GHOST_FREEZE_EN
   logic [FW-1:0]         freeze_q, freeze_d;
`endif

   logic tick_c;
   logic hit_acc_c;

   assign tick_c    = (state_q == ST_PLAYING) && (timer_q == TW'(MOVE_DELAY - 1));
   assign hit_acc_c = (state_q == ST_PLAYING) && (holdoff_q == '0) && (|bus.collision_i);

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state_q;
      lives_d       = lives_q;
      timer_d       = timer_q;
      sweep_idx_d   = sweep_idx_q;
      holdoff_d     = (holdoff_q != '0) ? holdoff_q - HW'(1) : '0;
      move_en_d     = '0;
      ghost_reset_d = 1'b0;
      hit_d         = 1'b0;
`ifdef GHOST_FREEZE_EN
      freeze_d      = freeze_q;
`endif

      case (state_q)
         ST_TITLE: begin
            timer_d     = '0;
            sweep_idx_d = SWEEP_IDLE;
            if (bus.start_i) begin
               state_d       = ST_PLAYING;
               lives_d       = 2'(LIVES_INIT);
               ghost_reset_d = 1'b1;
               holdoff_d     = HW'(HIT_HOLDOFF);
            end
         end

         ST_PLAYING: begin
            if (hit_acc_c) begin
               // Hit wins over any tick or in-flight sweep.
               hit_d       = 1'b1;
               timer_d     = '0;
               sweep_idx_d = SWEEP_IDLE;
               if (lives_q <= 2'd1) begin
                  state_d = ST_GAME_OVER;
                  lives_d = 2'd0;
               end else begin
                  lives_d       = lives_q - 2'd1;
                  ghost_reset_d = 1'b1;
                  holdoff_d     = HW'(HIT_HOLDOFF);
               end
            end else begin
               timer_d = tick_c ? '0 : timer_q + TW'(1);
               if (sweep_idx_q < SWEEP_IDLE) begin
                  move_en_d   = NUM_GHOSTS'(1) << sweep_idx_q;
                  sweep_idx_d = sweep_idx_q + SW'(1);
               end
               if (tick_c) begin
`ifdef GHOST_FREEZE_EN
                  if (freeze_q != '0) begin
                     freeze_d = freeze_q - FW'(1);
                  end else begin
                     move_en_d   = NUM_GHOSTS'(1);
                     sweep_idx_d = SW'(1);
                  end
`else
                  move_en_d   = NUM_GHOSTS'(1);
                  sweep_idx_d = SW'(1);
`endif
               end
            end
         end

         ST_GAME_OVER: begin
            lives_d     = 2'd0;
            timer_d     = '0;
            sweep_idx_d = SWEEP_IDLE;
            if (bus.start_i) begin
               state_d = ST_TITLE;
            end
         end

         default: begin
            state_d     = ST_TITLE;
            timer_d     = '0;
            sweep_idx_d = SWEEP_IDLE;
         end
      endcase

`ifdef GHOST_FREEZE_EN
      // Every respawn pulse (including game start) re-arms the freeze.
      if (ghost_reset_d) begin
         freeze_d = FW'(FREEZE_TICKS);
      end
`endif
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_TITLE;
         lives_q       <= 2'd0;
         timer_q       <= '0;
         sweep_idx_q   <= SWEEP_IDLE;
         holdoff_q     <= '0;
         move_en_q     <= '0;
         ghost_reset_q <= 1'b0;
         hit_q         <= 1'b0;
`ifdef GHOST_FREEZE_EN
         freeze_q      <= '0;
`endif
      end else begin
         state_q       <= state_d;
         lives_q       <= lives_d;
         timer_q       <= timer_d;
         sweep_idx_q   <= sweep_idx_d;
         holdoff_q     <= holdoff_d;
         move_en_q     <= move_en_d;
         ghost_reset_q <= ghost_reset_d;
         hit_q         <= hit_d;
`ifdef GHOST_FREEZE_EN
         freeze_q      <= freeze_d;
`endif
      end
   end

   assign bus.move_en_o     = move_en_q;
   assign bus.ghost_reset_o = ghost_reset_q;
   assign bus.hit_o         = hit_q;
   assign bus.game_state_o  = state_q;
   assign bus.lives_o       = lives_q;

endmodule

// File: tb/tb_ghost_scheduler.sv
// Directed bench for ghost_scheduler (NUM_GHOSTS=3, MOVE_DELAY=8,
// LIVES_INIT=3, HIT_HOLDOFF=2). Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point, so each vector's expected
// values are the register contents after the edge that sampled its inputs.
module tb_ghost_scheduler;

   localparam int unsigned NG = 3;

   typedef struct {
      logic          start;
      logic [NG-1:0] coll;
      logic [NG-1:0] move;
      logic          gr;
      logic          hit;
      logic [1:0]    st;
      logic [1:0]    lives;
   } vec_t;

   logic clk_i;
   logic reset_n;
   int   n_tests;
   int   n_fail;
   vec_t vecs[$];

   ghost_scheduler_if #(.NUM_GHOSTS(NG)) gif ();

   ghost_scheduler #(
      .NUM_GHOSTS (NG),
      .MOVE_DELAY (8),
      .LIVES_INIT (3),
      .HIT_HOLDOFF(2)
   ) dut (
      .clk_i  (clk_i),
      .reset_n(reset_n),
      .bus    (gif)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [NG-1:0] mv, input logic gr,
                            input logic ht, input logic [1:0] st, input logic [1:0] lv);
      check({tag, " move_en"},     32'(gif.move_en_o),     32'(mv));
      check({tag, " ghost_reset"}, 32'(gif.ghost_reset_o), 32'(gr));
      check({tag, " hit"},         32'(gif.hit_o),         32'(ht));
      check({tag, " state"},       32'(gif.game_state_o),  32'(st));
      check({tag, " lives"},       32'(gif.lives_o),       32'(lv));
   endtask

   task automatic do_reset();
      gif.start_i     = 1'b0;
      gif.collision_i = '0;
      reset_n         = 1'b0;
      step();
      step();
      check_all("reset", 3'b000, 1'b0, 1'b0, 2'b00, 2'd0);
      @(negedge clk_i);
      reset_n = 1'b1;
      step();
   endtask

   function automatic void add(input logic s, input logic [NG-1:0] c, input logic [NG-1:0] m,
                               input logic g, input logic h, input logic [1:0] st, input logic [1:0] l);
      vec_t v;
      v.start = s; v.coll = c; v.move = m; v.gr = g; v.hit = h; v.st = st; v.lives = l;
      vecs.push_back(v);
   endfunction

   function automatic void add_idle(input int n, input logic [1:0] l);
      for (int i = 0; i < n; i++) add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'b10, l);
   endfunction

   initial begin
      n_tests = 0;
      n_fail  = 0;

      // Main game sequence; comments name the PLAYING cycle each row lands in.
      add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00, 2'd0);  // TITLE idle
      add(1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 2'b10, 2'd3);  // P0 start
      add_idle(7, 2'd3);                                   // P1..P7 (tick at P7)
      add(1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 2'b10, 2'd3);  // P8
      add(1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 2'b10, 2'd3);  // P9
      add(1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 2'b10, 2'd3);  // P10
      add_idle(1, 2'd3);                                   // P11
      add(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'b10, 2'd3);  // P12 start ignored
      add_idle(3, 2'd3);                                   // P13..P15 (tick)
      add(1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 2'b10, 2'd3);  // P16
      add(1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 2'b10, 2'd3);  // P17
      add(1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 2'b10, 2'd3);  // P18
      add_idle(5, 2'd3);                                   // P19..P23 (tick)
      add(1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 2'b10, 2'd3);  // P24
      add(1'b0, 3'b110, 3'b000, 1'b1, 1'b1, 2'b10, 2'd2);  // P25 hit mid-sweep
      add_idle(7, 2'd2);                                   // P26..P32 (tick P32)
      add(1'b0, 3'b001, 3'b000, 1'b1, 1'b1, 2'b10, 2'd1);  // P33 hit on tick
      add_idle(2, 2'd1);                                   // P34..P35
      add(1'b0, 3'b100, 3'b000, 1'b0, 1'b1, 2'b11, 2'd0);  // P36 last life
      add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'b11, 2'd0);  // GAME_OVER
      add(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00, 2'd0);  // back to TITLE
      add(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00, 2'd0);

      do_reset();

`ifndef GHOST_FREEZE_EN
      for (int i = 0; i < vecs.size(); i++) begin
         gif.start_i     = vecs[i].start;
         gif.collision_i = vecs[i].coll;
         step();
         check_all($sformatf("vec%0d", i), vecs[i].move, vecs[i].gr, vecs[i].hit,
                   vecs[i].st, vecs[i].lives);
         if (gif.move_en_o != 3'b000 && gif.move_en_o != 3'b001 &&
             gif.move_en_o != 3'b010 && gif.move_en_o != 3'b100)
            check($sformatf("vec%0d onehot", i), 32'(gif.move_en_o), 32'(0));
      end

      // Asynchronous reset mid-sweep: outputs clear without a clock edge.
      do_reset();
      gif.start_i = 1'b1;
      step();
      gif.start_i = 1'b0;
      for (int k = 1; k <= 8; k++) step();
      check_all("pre-async", 3'b001, 1'b0, 1'b0, 2'b10, 2'd3);
      #2;
      reset_n = 1'b0;
      #1;
      check_all("async", 3'b000, 1'b0, 1'b0, 2'b00, 2'd0);
      @(negedge clk_i);
      reset_n = 1'b1;
      step();
`endif

      // Collision held high: one hit every 3 cycles until game over.
      do_reset();
      gif.collision_i = 3'b111;
      gif.start_i     = 1'b1;
      step();
      gif.start_i = 1'b0;
      for (int k = 0; k <= 12; k++) begin
         logic       e_hit;
         logic       e_gr;
         logic [1:0] e_lv;
         logic [1:0] e_st;
         if (k > 0) step();
         e_hit = (k == 3) || (k == 6) || (k == 9);
         e_gr  = (k == 0) || (k == 3) || (k == 6);
         e_lv  = (k < 3) ? 2'd3 : (k < 6) ? 2'd2 : (k < 9) ? 2'd1 : 2'd0;
         e_st  = (k < 9) ? 2'b10 : 2'b11;
         check_all($sformatf("held P%0d", k), 3'b000, e_gr, e_hit, e_st, e_lv);
      end
      gif.collision_i = '0;
      gif.start_i     = 1'b1;
      step();
      gif.start_i = 1'b0;
      check_all("over->title", 3'b000, 1'b0, 1'b0, 2'b00, 2'd0);

`ifdef GHOST_FREEZE_EN
      // Three frozen ticks (P7, P15, P23); first strobe follows the tick at P31.
      begin
         int first_k;
         do_reset();
         gif.start_i = 1'b1;
         step();
         gif.start_i = 1'b0;
         check_all("freeze start", 3'b000, 1'b1, 1'b0, 2'b10, 2'd3);
         first_k = -1;
         for (int k = 1; k <= 60; k++) begin
            step();
            if (gif.move_en_o != 3'b000) begin
               first_k = k;
               break;
            end
         end
         check("freeze first strobe cycle", 32'(first_k), 32'(32));
         check("freeze first strobe value", 32'(gif.move_en_o), 32'(3'b001));
         step();
         check("freeze second strobe", 32'(gif.move_en_o), 32'(3'b010));
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
